bcd_subtractor_serial: RTL and testbench

Digit-serial signed BCD subtractor for the calculator datapath. It is the subtract-direction counterpart to the two-digit BCD adder. It computes |A − B| as packed BCD plus a sign flag, processing one decimal digit per clock. When the raw difference is negative, it runs a ten's-complement pass to produce the magnitude. It sits between operand registers and the display/result register and uses a start/busy/done handshake.

---
 rtl/bcd_subtractor_serial.sv | 190 +++++++++++++++++++
 tb/tb_bcd_subtractor_serial.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial signed BCD subtractor: computes |A - B| one decimal digit per clock,
// followed by a ten's-complement pass when the raw difference is negative.
module bcd_subtractor_serial #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   DIFF_BCD,
    output logic                  NEGATIVE,
    output logic                  INVALID
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_COMP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            borrow_q, borrow_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    r_q, r_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            neg_q, neg_d;
    logic            inv_q, inv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [4:0]      step_s;
    logic            last_s;

    function automatic logic [3:0] get_nib(input logic [W-1:0] v, input logic [IW-1:0] i);
        get_nib = v[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [W-1:0] set_nib(input logic [W-1:0] v, input logic [IW-1:0] i,
                                             input logic [3:0] d);
        logic [W-1:0] o;
        o = v;
        o[{i, 2'b00} +: 4] = d;
        set_nib = o;
    endfunction

    function automatic logic has_bad_nib(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        has_bad_nib = bad;
    endfunction

    // Returns {borrow_out, digit}; a negative 5-bit intermediate is folded back by +10.
    function automatic logic [4:0] sub_digit(input logic [3:0] a, input logic [3:0] b,
                                             input logic bin);
        logic [4:0] t;
        t = {1'b0, a} - {1'b0, b} - {4'd0, bin};
        if (t[4]) begin
            t = t + 5'd10;
            sub_digit = {1'b1, t[3:0]};
        end else begin
            sub_digit = {1'b0, t[3:0]};
        end
    endfunction

    // Next-state and datapath: accept requests, walk digits, load results on DONE entry.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        diff_d   = diff_q;
        neg_d    = neg_q;
        inv_d    = inv_q;
        step_s   = 5'd0;
        last_s   = (idx_q == IW'(DIGITS - 1));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    idx_d    = {IW{1'b0}};
                    borrow_d = 1'b0;
                    r_d      = {W{1'b0}};
                    if (has_bad_nib(A) || has_bad_nib(B)) begin
                        state_d = S_DONE;
                        diff_d  = {W{1'b0}};
                        neg_d   = 1'b0;
                        inv_d   = 1'b1;
                    end else begin
                        state_d = S_SUB;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SUB: begin
                step_s   = sub_digit(get_nib(a_q, idx_q), get_nib(b_q, idx_q), borrow_q);
                r_d      = set_nib(r_q, idx_q, step_s[3:0]);
                borrow_d = step_s[4];
                if (last_s) begin
                    idx_d = {IW{1'b0}};
                    if (step_s[4]) begin
                        // Raw difference wrapped negative: recover magnitude by complementing.
                        state_d  = S_COMP;
                        borrow_d = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        diff_d  = r_d;
                        neg_d   = 1'b0;
                        inv_d   = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_COMP: begin
                step_s   = sub_digit(4'd0, get_nib(r_q, idx_q), borrow_q);
                r_d      = set_nib(r_q, idx_q, step_s[3:0]);
                borrow_d = step_s[4];
                if (last_s) begin
                    idx_d   = {IW{1'b0}};
                    state_d = S_DONE;
                    diff_d  = r_d;
                    neg_d   = 1'b1;
                    inv_d   = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SUB) || (state_d == S_COMP);
        done_d = (state_d == S_DONE);
    end

    // State, operand, result and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= {IW{1'b0}};
            borrow_q <= 1'b0;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            r_q      <= {W{1'b0}};
            diff_q   <= {W{1'b0}};
            neg_q    <= 1'b0;
            inv_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            diff_q   <= diff_d;
            neg_q    <= neg_d;
            inv_q    <= inv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign DIFF_BCD = diff_q;
    assign NEGATIVE = neg_q;
    assign INVALID  = inv_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Self-checking bench for bcd_subtractor_serial: directed table, integer reference model
// with random operands, held-start back-to-back and mid-operation reset sequences.
module tb_bcd_subtractor_serial;

    localparam int D = 2;
    localparam int W = 4 * D;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] DIFF_BCD;
    logic         NEGATIVE;
    logic         INVALID;

    int n_checks = 0;
    int n_errors = 0;

    bcd_subtractor_serial #(.DIGITS(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .DIFF_BCD (DIFF_BCD),
        .NEGATIVE (NEGATIVE),
        .INVALID  (INVALID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         neg;
        logic         inv;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal arithmetic on the operand values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] diff, output logic neg,
                         output logic inv, output int lat);
        int va, vb, m;
        logic [3:0] na, nb;
        va = 0; vb = 0; inv = 1'b0;
        for (int i = D - 1; i >= 0; i--) begin
            na = a[i*4 +: 4];
            nb = b[i*4 +: 4];
            if (na > 4'd9 || nb > 4'd9) inv = 1'b1;
            va = va * 10 + int'(na);
            vb = vb * 10 + int'(nb);
        end
        diff = '0;
        if (inv) begin
            neg = 1'b0;
            lat = 0;
        end else begin
            neg = (va < vb);
            m   = neg ? (vb - va) : (va - vb);
            lat = neg ? 2 * D : D;
            for (int i = 0; i < D; i++) begin
                diff[i*4 +: 4] = 4'(m % 10);
                m = m / 10;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ediff, input logic eneg,
                          input logic einv, input int elat, input string tag);
        int found;
        int busy_bad;
        found = -1;
        busy_bad = 0;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                found = c;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        check({tag, " latency"}, 32'(found), 32'(elat));
        if (found >= 0) begin
            check({tag, " busy_run"}, 32'(busy_bad), 32'd0);
            check({tag, " busy_done"}, {31'd0, busy}, 32'd0);
            check({tag, " diff"}, {24'd0, DIFF_BCD}, {24'd0, ediff});
            check({tag, " neg"}, {31'd0, NEGATIVE}, {31'd0, eneg});
            check({tag, " inv"}, {31'd0, INVALID}, {31'd0, einv});
            @(negedge clk);
            check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        end
    endtask

    vec_t tbl[$];

    initial begin
        logic [W-1:0] ra, rb, ediff;
        logic         eneg, einv;
        int           elat, pulses, first, second, stray;

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset diff", {24'd0, DIFF_BCD}, 32'd0);
        check("reset neg_inv", {30'd0, NEGATIVE, INVALID}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back('{8'h45, 8'h12, 8'h33, 1'b0, 1'b0, 2});
        tbl.push_back('{8'h12, 8'h45, 8'h33, 1'b1, 1'b0, 4});
        tbl.push_back('{8'h00, 8'h99, 8'h99, 1'b1, 1'b0, 4});
        tbl.push_back('{8'h50, 8'h50, 8'h00, 1'b0, 1'b0, 2});
        tbl.push_back('{8'h30, 8'h01, 8'h29, 1'b0, 1'b0, 2});
        tbl.push_back('{8'h3A, 8'h01, 8'h00, 1'b0, 1'b1, 0});
        tbl.push_back('{8'h45, 8'h12, 8'h33, 1'b0, 1'b0, 2});
        tbl.push_back('{8'h00, 8'h01, 8'h01, 1'b1, 1'b0, 4});
        tbl.push_back('{8'h99, 8'h00, 8'h99, 1'b0, 1'b0, 2});
        tbl.push_back('{8'h10, 8'h09, 8'h01, 1'b0, 1'b0, 2});
        tbl.push_back('{8'h21, 8'hF0, 8'h00, 1'b0, 1'b1, 0});
        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].neg, tbl[i].inv, tbl[i].lat,
                   $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            for (int d = 0; d < D; d++) begin
                ra[d*4 +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                            : 4'($urandom_range(0, 9));
                rb[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            model(ra, rb, ediff, eneg, einv, elat);
            run_op(ra, rb, ediff, eneg, einv, elat, $sformatf("rnd%0d", i));
        end

        // Start held high: second request accepted in the first DONE cycle.
        pulses = 0; first = -1; second = -1;
        @(negedge clk);
        A = 8'h45; B = 8'h12; start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    first = c;
                    check("held1 diff", {24'd0, DIFF_BCD}, 32'h33);
                    check("held1 neg", {31'd0, NEGATIVE}, 32'd0);
                    A = 8'h12; B = 8'h45;
                end else if (pulses == 2) begin
                    second = c;
                    check("held2 diff", {24'd0, DIFF_BCD}, 32'h33);
                    check("held2 neg", {31'd0, NEGATIVE}, 32'd1);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("held first", 32'(first), 32'd2);
        check("held second", 32'(second), 32'd7);
        check("held pulses", 32'(pulses), 32'd2);

        // Asynchronous reset during SUB of 0x12 - 0x45.
        run_op(8'h12, 8'h45, 8'h33, 1'b1, 1'b0, 4, "pre_rst");
        @(negedge clk);
        A = 8'h12; B = 8'h45; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("rst busy_before", {31'd0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst diff", {24'd0, DIFF_BCD}, 32'd0);
        check("rst neg", {31'd0, NEGATIVE}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        check("rst no_done", 32'(stray), 32'd0);
        run_op(8'h45, 8'h12, 8'h33, 1'b0, 1'b0, 2, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
